// File: rtl/ram_bank.sv
// ram_bank: data RAM, status nibbles and output port for the 4-bit multiplexed
// CPU bus. Each instance answers SRC/RAM-group instructions for its CHIP_ID.
// It also has a Wishbone backdoor that moves eight nibbles per 32-bit word.
module ram_bank #(
  parameter int CHIP_ID        = 0,
  parameter int NUM_REGS       = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  data_i,
  output logic [3:0]  data_o,
  output logic        data_en,
  input  logic        sync,
  input  logic        cmd_n,
  output logic [3:0]  out,
  input  logic [31:0] wb_data_i,
  input  logic [31:0] wb_addr_i,
  input  logic        wb_cyc_i,
  input  logic        wb_strobe_i,
  input  logic        wb_we_i,
  output logic [31:0] wb_data_o,
  output logic        wb_ack_o
);

  localparam int         NUM_CHARS = NUM_REGS * 16;
  localparam int         NUM_STATS = NUM_REGS * 4;
  localparam logic [1:0] CHIP_SEL  = 2'(CHIP_ID);

  // Bus cycle tracking and decode state
  logic [2:0]  cycle_q, cycle_d;
  logic [1:0]  reg_addr_q, reg_addr_d;
  logic [3:0]  char_addr_q, char_addr_d;
  logic        selected_q, selected_d;
  logic        src_active_q, src_active_d;
  logic        inst_active_q, inst_active_d;
  logic [3:0]  inst_q, inst_d;

  // Storage. The arrays are always sized for four registers.
  // Entries of unpopulated registers are never written and never read back.
  logic [3:0]  mem_q [64];
  logic [3:0]  mem_d [64];
  logic [3:0]  status_q [16];
  logic [3:0]  status_d [16];
  logic [3:0]  out_q, out_d;
  logic [3:0]  rd_q, rd_d;
  logic        wb_ack_q, wb_ack_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic        cmd;
  logic        reg_pop;
  logic        exec;
  logic        op_wrm, op_wmp, op_wrn, op_rdm, op_rdn;
  logic [5:0]  char_idx;
  logic [3:0]  stat_idx;
  logic        wb_accept;
  logic [2:0]  wb_word;
  logic        wb_sidx;
  logic [31:0] mem_word, stat_word, wb_rd_word;
  logic [5:0]  lane_mflat [8];
  logic [3:0]  lane_sflat [8];
  logic [7:0]  lane_mpop, lane_spop;
  logic        unused_bits;

  assign cmd      = ~cmd_n;
  assign reg_pop  = int'(reg_addr_q) < NUM_REGS;
  assign exec     = inst_active_q && (cycle_q == 3'd6);
  assign op_wrm   = inst_q == 4'h0;
  assign op_wmp   = inst_q == 4'h1;
  assign op_wrn   = inst_q[3:2] == 2'b01;
  assign op_rdm   = (inst_q == 4'h8) || (inst_q == 4'h9) || (inst_q == 4'hB);
  assign op_rdn   = inst_q[3:2] == 2'b11;
  assign char_idx = {reg_addr_q, char_addr_q};
  assign stat_idx = {reg_addr_q, inst_q[1:0]};

  // The backdoor is only served at cycle 7, so it never meets a bus write.
  assign wb_accept = (cycle_q == 3'd7) && wb_cyc_i && wb_strobe_i && !wb_ack_q;
  assign wb_word   = wb_addr_i[4:2];
  assign wb_sidx   = wb_addr_i[2];

  // Reads drive 0 for an unpopulated register, but the bus is still driven.
  assign data_en = exec && (op_rdm || op_rdn);
  assign data_o  = (!data_en || !reg_pop) ? 4'h0 : (op_rdn ? status_q[stat_idx] : rd_q);

  assign out       = out_q;
  assign wb_ack_o  = wb_ack_q;
  assign wb_data_o = wb_data_q;

  // sync is not needed because the cycle is derived internally.
  // Only address bits [9:8] and [4:2] take part in decoding.
  assign unused_bits = ^{sync, wb_addr_i[31:10], wb_addr_i[7:5], wb_addr_i[1:0]};

  // One lane per nibble of a backdoor word.
  // Each lane has its flat char/status index and a flag saying whether that index is populated.
  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign lane_mflat[gi] = {wb_word, 3'(gi)};
    assign lane_sflat[gi] = {wb_sidx, 3'(gi)};
    assign lane_mpop[gi]  = int'(lane_mflat[gi]) < NUM_CHARS;
    assign lane_spop[gi]  = int'(lane_sflat[gi]) < NUM_STATS;
    assign mem_word[4*gi +: 4]  = lane_mpop[gi] ? mem_q[lane_mflat[gi]] : 4'h0;
    assign stat_word[4*gi +: 4] = lane_spop[gi] ? status_q[lane_sflat[gi]] : 4'h0;
  end

  // Backdoor read word selected by address bits [9:8]
  always_comb begin
    wb_rd_word = 32'h0;
    case (wb_addr_i[9:8])
      2'd0:    wb_rd_word = mem_word;
      2'd1:    wb_rd_word = stat_word;
      2'd2:    wb_rd_word = {28'h0, out_q};
      default: wb_rd_word = 32'h0;
    endcase
  end

  // SRC and instruction decode from the multiplexed bus
  always_comb begin
    cycle_d       = cycle_q + 3'd1;
    reg_addr_d    = reg_addr_q;
    char_addr_d   = char_addr_q;
    selected_d    = selected_q;
    src_active_d  = src_active_q;
    inst_d        = inst_q;
    inst_active_d = inst_active_q;
    if (cmd && cycle_q == 3'd6) begin
      if (data_i[3:2] == CHIP_SEL) begin
        selected_d   = 1'b1;
        reg_addr_d   = data_i[1:0];
        src_active_d = 1'b1;
      end else begin
        selected_d = 1'b0;
      end
    end
    if (!cmd && cycle_q == 3'd7) begin
      inst_active_d = 1'b0;
      if (src_active_q) begin
        char_addr_d  = data_i;
        src_active_d = 1'b0;
      end
    end
    if (cmd && cycle_q == 3'd4 && selected_q) begin
      inst_d        = data_i;
      inst_active_d = 1'b1;
    end
  end

  // Next state of the storage: reset clear, bus writes at cycle 6, backdoor writes at cycle 7
  always_comb begin
    mem_d     = mem_q;
    status_d  = status_q;
    out_d     = out_q;
    rd_d      = mem_q[char_idx];
    wb_ack_d  = 1'b0;
    wb_data_d = wb_data_q;
    if (reset) begin
      if (CLEAR_ON_RESET) begin
        for (int i = 0; i < 64; i++) mem_d[i] = 4'h0;
      end
      for (int i = 0; i < 16; i++) status_d[i] = 4'h0;
      out_d     = 4'h0;
      wb_data_d = 32'h0;
    end else begin
      if (exec && reg_pop && op_wrm) mem_d[char_idx] = data_i;
      if (exec && reg_pop && op_wrn) status_d[stat_idx] = data_i;
      if (exec && op_wmp) out_d = data_i;
      if (wb_accept) begin
        wb_ack_d  = 1'b1;
        wb_data_d = wb_rd_word;
        if (wb_we_i) begin
          for (int k = 0; k < 8; k++) begin
            if (wb_addr_i[9:8] == 2'd0 && lane_mpop[k]) mem_d[lane_mflat[k]] = wb_data_i[4*k +: 4];
            if (wb_addr_i[9:8] == 2'd1 && lane_spop[k]) status_d[lane_sflat[k]] = wb_data_i[4*k +: 4];
          end
          if (wb_addr_i[9:8] == 2'd2) out_d = wb_data_i[3:0];
        end
      end
    end
  end

  // Decode state registers, cleared by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_q       <= 3'd0;
      reg_addr_q    <= 2'd3;
      char_addr_q   <= 4'hF;
      selected_q    <= 1'b0;
      src_active_q  <= 1'b0;
      inst_q        <= 4'h0;
      inst_active_q <= 1'b0;
    end else begin
      cycle_q       <= cycle_d;
      reg_addr_q    <= reg_addr_d;
      char_addr_q   <= char_addr_d;
      selected_q    <= selected_d;
      src_active_q  <= src_active_d;
      inst_q        <= inst_d;
      inst_active_q <= inst_active_d;
    end
  end

  // Storage and backdoor registers; their reset behaviour lives in the next-state logic
  always_ff @(posedge clock) begin
    mem_q     <= mem_d;
    status_q  <= status_d;
    out_q     <= out_d;
    rd_q      <= rd_d;
    wb_ack_q  <= wb_ack_d;
    wb_data_q <= wb_data_d;
  end

endmodule

// File: tb/tb_ram_bank.sv
// tb_ram_bank: two banks share the bus and the backdoor.
// Bank A is CHIP_ID 1 with 4 registers and is cleared on reset.
// Bank B is CHIP_ID 2 with 2 registers and keeps its memory through reset.
// Random transactions are checked against a transaction-level model.
module tb_ram_bank;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  data_i = 4'h0;
  logic        cmd_n = 1'b1;
  logic        sync = 1'b0;
  logic [31:0] wb_data_i = 32'h0;
  logic [31:0] wb_addr_i = 32'h0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_strobe_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [3:0]  data_o_w [2];
  logic        data_en_w [2];
  logic [3:0]  out_w [2];
  logic [31:0] wb_data_o_w [2];
  logic        wb_ack_w [2];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: what each bank holds, in flat char/status numbering
  logic [3:0] m_mem [2][64];
  logic [3:0] m_stat [2][16];
  logic [3:0] m_out [2];
  bit         m_sel [2];
  int         m_reg [2];
  int         m_char [2];

  always #5 clock = ~clock;

  ram_bank #(.CHIP_ID(1), .NUM_REGS(4), .CLEAR_ON_RESET(1'b1)) u_bank_a (
    .clock(clock), .reset(reset), .data_i(data_i), .data_o(data_o_w[0]),
    .data_en(data_en_w[0]), .sync(sync), .cmd_n(cmd_n), .out(out_w[0]),
    .wb_data_i(wb_data_i), .wb_addr_i(wb_addr_i), .wb_cyc_i(wb_cyc_i),
    .wb_strobe_i(wb_strobe_i), .wb_we_i(wb_we_i), .wb_data_o(wb_data_o_w[0]),
    .wb_ack_o(wb_ack_w[0])
  );

  ram_bank #(.CHIP_ID(2), .NUM_REGS(2), .CLEAR_ON_RESET(1'b0)) u_bank_b (
    .clock(clock), .reset(reset), .data_i(data_i), .data_o(data_o_w[1]),
    .data_en(data_en_w[1]), .sync(sync), .cmd_n(cmd_n), .out(out_w[1]),
    .wb_data_i(wb_data_i), .wb_addr_i(wb_addr_i), .wb_cyc_i(wb_cyc_i),
    .wb_strobe_i(wb_strobe_i), .wb_we_i(wb_we_i), .wb_data_o(wb_data_o_w[1]),
    .wb_ack_o(wb_ack_w[1])
  );

  function automatic int nregs(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic logic [1:0] chip_of(input int i);
    return (i == 0) ? 2'd1 : 2'd2;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc = (cyc + 1) % 8;
    sync = (cyc == 7);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_sel[i] = 1'b0;
      m_reg[i] = 3;
      m_char[i] = 15;
      m_out[i] = 4'h0;
      for (int s = 0; s < 16; s++) m_stat[i][s] = 4'h0;
      if (i == 0) for (int c = 0; c < 64; c++) m_mem[i][c] = 4'h0;
    end
  endtask

  function automatic logic [31:0] model_word(input int i, input logic [31:0] addr);
    logic [31:0] w;
    int idx;
    w = 32'h0;
    for (int k = 0; k < 8; k++) begin
      if (addr[9:8] == 2'd0) begin
        idx = int'(addr[4:2]) * 8 + k;
        if (idx < nregs(i) * 16) w[4*k +: 4] = m_mem[i][idx];
      end else if (addr[9:8] == 2'd1) begin
        idx = int'(addr[2]) * 8 + k;
        if (idx < nregs(i) * 4) w[4*k +: 4] = m_stat[i][idx];
      end
    end
    if (addr[9:8] == 2'd2) w[3:0] = m_out[i];
    return w;
  endfunction

  task automatic model_wb_write(input logic [31:0] addr, input logic [31:0] wdata);
    int idx;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 8; k++) begin
        if (addr[9:8] == 2'd0) begin
          idx = int'(addr[4:2]) * 8 + k;
          if (idx < nregs(i) * 16) m_mem[i][idx] = wdata[4*k +: 4];
        end else if (addr[9:8] == 2'd1) begin
          idx = int'(addr[2]) * 8 + k;
          if (idx < nregs(i) * 4) m_stat[i][idx] = wdata[4*k +: 4];
        end
      end
      if (addr[9:8] == 2'd2) m_out[i] = wdata[3:0];
    end
  endtask

  task automatic do_reset(input int hold);
    reset = 1'b1;
    cmd_n = 1'b1;
    wb_cyc_i = 1'b0;
    wb_strobe_i = 1'b0;
    repeat (hold) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    cyc = 0;
    model_reset();
    $display("reset released");
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("rst_data_en%0d", i), 32'(data_en_w[i]), 32'h0);
      check_eq($sformatf("rst_out%0d", i), 32'(out_w[i]), 32'h0);
      check_eq($sformatf("rst_ack%0d", i), 32'(wb_ack_w[i]), 32'h0);
      check_eq($sformatf("rst_wbdata%0d", i), wb_data_o_w[i], 32'h0);
    end
  endtask

  task automatic run_to(input int c);
    cmd_n = 1'b1;
    while (cyc != c) begin
      data_i = 4'($urandom);
      tick();
    end
  endtask

  task automatic bus_src(input logic [3:0] hi, input logic [3:0] lo);
    run_to(6);
    cmd_n = 1'b0;
    data_i = hi;
    tick();
    cmd_n = 1'b1;
    data_i = lo;
    tick();
    for (int i = 0; i < 2; i++) begin
      if (hi[3:2] == chip_of(i)) begin
        m_sel[i] = 1'b1;
        m_reg[i] = int'(hi[1:0]);
        m_char[i] = int'(lo);
      end else begin
        m_sel[i] = 1'b0;
      end
    end
    $display("src chip/reg 0x%h char 0x%h", hi, lo);
  endtask

  task automatic check_idle(input string tag);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("%s_en%0d", tag, i), 32'(data_en_w[i]), 32'h0);
      check_eq($sformatf("%s_do%0d", tag, i), 32'(data_o_w[i]), 32'h0);
    end
  endtask

  task automatic bus_op(input logic [3:0] op, input logic [3:0] val);
    bit exp_en [2];
    logic [3:0] exp_d [2];
    bit pop;
    int ci, si;
    run_to(4);
    cmd_n = 1'b0;
    data_i = op;
    #1 check_idle("c4");
    tick();
    cmd_n = 1'b1;
    data_i = 4'($urandom);
    #1 check_idle("c5");
    tick();
    data_i = val;
    #1;
    for (int i = 0; i < 2; i++) begin
      exp_en[i] = 1'b0;
      exp_d[i] = 4'h0;
      pop = m_reg[i] < nregs(i);
      ci = m_reg[i] * 16 + m_char[i];
      si = m_reg[i] * 4 + int'(op[1:0]);
      if (m_sel[i] && (op == 4'h8 || op == 4'h9 || op == 4'hB)) begin
        exp_en[i] = 1'b1;
        exp_d[i] = pop ? m_mem[i][ci] : 4'h0;
      end else if (m_sel[i] && op >= 4'hC) begin
        exp_en[i] = 1'b1;
        exp_d[i] = pop ? m_stat[i][si] : 4'h0;
      end
      check_eq($sformatf("c6_en%0d", i), 32'(data_en_w[i]), 32'(exp_en[i]));
      check_eq($sformatf("c6_do%0d", i), 32'(data_o_w[i]), 32'(exp_d[i]));
      if (m_sel[i]) begin
        if (op == 4'h0 && pop) m_mem[i][ci] = val;
        if (op == 4'h1) m_out[i] = val;
        if (op[3:2] == 2'b01 && pop) m_stat[i][si] = val;
      end
    end
    tick();
    data_i = 4'($urandom);
    #1 check_idle("c7");
    for (int i = 0; i < 2; i++) check_eq($sformatf("out%0d", i), 32'(out_w[i]), 32'(m_out[i]));
    tick();
    $display("op 0x%h data 0x%h", op, val);
  endtask

  task automatic wb_xfer(input bit we, input logic [31:0] addr, input logic [31:0] wdata, input bit chk);
    logic [31:0] exp [2];
    int waited;
    for (int i = 0; i < 2; i++) exp[i] = model_word(i, addr);
    wb_cyc_i = 1'b1;
    wb_strobe_i = 1'b1;
    wb_we_i = we;
    wb_addr_i = addr;
    wb_data_i = wdata;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!wb_ack_w[0] && waited < 16);
    if (!wb_ack_w[0]) begin
      check_eq("wb_ack_timeout", 32'h0, 32'h1);
    end else begin
      check_eq("wb_ack_cycle", 32'(cyc), 32'h0);
      check_eq("wb_ack_b", 32'(wb_ack_w[1]), 32'h1);
      if (chk) begin
        for (int i = 0; i < 2; i++) check_eq($sformatf("wb_rd%0d", i), wb_data_o_w[i], exp[i]);
      end
    end
    if (we) model_wb_write(addr, wdata);
    wb_cyc_i = 1'b0;
    wb_strobe_i = 1'b0;
    wb_we_i = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) check_eq($sformatf("wb_ack_width%0d", i), 32'(wb_ack_w[i]), 32'h0);
    $display("wb %s addr 0x%03h data 0x%08h", we ? "write" : "read", addr[9:0], wdata);
  endtask

  task automatic dump_all();
    for (int w = 0; w < 8; w++) wb_xfer(1'b0, 32'(w * 4), 32'h0, 1'b1);
    wb_xfer(1'b0, 32'h100, 32'h0, 1'b1);
    wb_xfer(1'b0, 32'h104, 32'h0, 1'b1);
    wb_xfer(1'b0, 32'h200, 32'h0, 1'b1);
    wb_xfer(1'b0, 32'h300, 32'h0, 1'b1);
  endtask

  initial begin
    int first_ack, second_ack, n_acks, r;
    logic [31:0] addr;

    do_reset(3);

    // Make both banks' memory known before anything is compared.
    for (int w = 0; w < 8; w++) wb_xfer(1'b1, 32'(w * 4), $urandom, 1'b0);

    // WRM to bank A reg 1 char 10, then read back through the backdoor.
    bus_src(4'h5, 4'hA);
    bus_op(4'h0, 4'h7);
    wb_xfer(1'b0, 32'h00C, 32'h0, 1'b1);
    wb_xfer(1'b0, 32'h014, 32'h0, 1'b1);

    // WMP, then read the port through the backdoor.
    bus_op(4'h1, 4'hC);
    wb_xfer(1'b0, 32'h200, 32'h0, 1'b1);

    // Backdoor status write, then read RD2 of reg 1 over the bus.
    wb_xfer(1'b1, 32'h100, 32'h87654321, 1'b1);
    bus_src(4'h5, 4'h0);
    bus_op(4'hE, 4'h0);

    // SRC to an absent chip deselects everyone, and a matching SRC restores selection.
    bus_src(4'hC, 4'h2);
    bus_op(4'h0, 4'h9);
    bus_op(4'h9, 4'h0);
    bus_src(4'h4, 4'h2);
    bus_op(4'h9, 4'h0);

    // Bank B has two registers, so reg 3 is unpopulated.
    bus_src(4'hB, 4'h4);
    bus_op(4'h0, 4'h5);
    bus_op(4'h9, 4'h0);
    bus_op(4'hD, 4'h0);
    wb_xfer(1'b0, 32'h018, 32'h0, 1'b1);

    // A held request raised at cycle 2 is acknowledged after each cycle 7, one clock wide.
    run_to(2);
    wb_cyc_i = 1'b1;
    wb_strobe_i = 1'b1;
    wb_we_i = 1'b0;
    wb_addr_i = 32'h200;
    first_ack = -1;
    second_ack = -1;
    n_acks = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (wb_ack_w[0]) begin
        n_acks++;
        if (first_ack < 0) begin
          first_ack = t;
          for (int i = 0; i < 2; i++)
            check_eq($sformatf("held_rd%0d", i), wb_data_o_w[i], model_word(i, 32'h200));
        end else if (second_ack < 0) begin
          second_ack = t;
        end
      end
    end
    wb_cyc_i = 1'b0;
    wb_strobe_i = 1'b0;
    check_eq("held_first_ack", 32'(first_ack), 32'd6);
    check_eq("held_second_ack", 32'(second_ack), 32'd14);
    check_eq("held_ack_count", 32'(n_acks), 32'd2);
    $display("wb held read acks at clocks %0d and %0d", first_ack, second_ack);
    tick();

    // Random mix of SRC, RAM-group instructions and backdoor accesses
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      if (r < 3) begin
        bus_src(4'($urandom), 4'($urandom));
      end else if (r < 8) begin
        bus_op(4'($urandom), 4'($urandom));
      end else begin
        addr = 32'h0;
        addr[9:8] = 2'($urandom);
        addr[7:5] = 3'($urandom);
        addr[4:2] = 3'($urandom);
        wb_xfer(1'($urandom), addr, $urandom, 1'b1);
      end
    end
    dump_all();

    // A reset at cycle 5 of a WRM aborts it. Bank B keeps its memory and bank A is cleared.
    bus_src(4'h9, 4'h3);
    run_to(4);
    cmd_n = 1'b0;
    data_i = 4'h0;
    tick();
    cmd_n = 1'b1;
    data_i = ~m_mem[1][19];
    do_reset(2);
    dump_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
